crc32_stream_ctrl: RTL and testbench
====================================

# crc32_stream_ctrl

Byte-stream sequencer for the bit-serial CRC-32 engine. It accepts framed bytes over a valid/ready handshake and clears the engine at frame start. It serialises each byte LSB-first into the engine, optionally appends the 32 zero augmentation bits, and then presents the engine's CRC and the frame byte count until consumed. It sits between a byte producer (UART RX, file loader) and the engine, which has a clock-enable input `crc_en`.

## Interface
- `LEN_W`, 16: width of the frame byte counter.

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  byte available
- `in_data`  in  8  byte, shifted LSB first
- `in_last`  in  1  qualifies `in_data` as the final byte of the frame
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`
- `abort`  in  1  drop the current frame
- `crc_clr`  out  1  engine clear, one-cycle pulse
- `crc_en`  out  1  engine shifts in `crc_bit` on this edge
- `crc_bit`  out  1  serial bit to the engine
- `crc_val`  in  32  engine CRC register
- `out_valid`  out  1  result valid
- `out_crc`  out  32  equals `crc_val` while `out_valid`, else 0
- `out_len`  out  LEN_W  bytes in the frame; saturates at all-ones
- `out_ready`  in  1  result consumed when `out_valid & out_ready`

## Operation
- States: IDLE, CLR, SHIFT, WAIT, FLUSH, DONE.
- Internal registers: byte shift register `sh[7:0]`, `bit_cnt[2:0]`, `last_r`, `flush_cnt[4:0]`, `len[LEN_W-1:0]`.
- IDLE:
  - `in_ready=1`.
  - On accept: load `sh`, `last_r=in_last`, `len=1`, go to CLR.
- CLR:
  - `crc_clr=1`, `crc_en=0`.
  - Next state SHIFT, `bit_cnt=0`.
- SHIFT:
  - `crc_en=1`, `crc_bit=sh[0]`.
  - Each cycle: `sh>>=1`, `bit_cnt++`.
  - At `bit_cnt==7`, `in_ready=!last_r`:
    - Byte accepted: reload `sh`, `last_r`, `len++` (saturating), stay in SHIFT with `bit_cnt=0`. Throughput is 8 cycles/byte.
    - `last_r=1`: go to FLUSH.
    - No byte accepted: go to WAIT.
- WAIT:
  - `in_ready=1`, `crc_en=0`; the engine holds its value.
  - On accept: go to SHIFT as above.
- FLUSH:
  - `crc_en=1`, `crc_bit=0`, for 32 cycles (`flush_cnt` 0..31).
  - Then go to DONE.
- DONE:
  - `out_valid=1`, `crc_en=0`, `in_ready=0`.
  - On `out_ready`: go to IDLE next cycle.
- Abort:
  - `abort` in CLR/SHIFT/WAIT/FLUSH: go to IDLE on the next edge.
  - No `out_valid`; any byte offered that cycle is not accepted (`in_ready` forced 0).
  - `abort` in IDLE/DONE is ignored.
- Outside SHIFT, `crc_bit=0`. `crc_en` is 0 in IDLE, CLR, WAIT and DONE.
- `in_last` is sampled only on an accepted byte.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - `in_ready=1` in the first post-reset cycle; all other outputs 0.
- Reset mid-frame: returns to IDLE with no `out_valid`. Engine contents are stale but cleared by the next CLR.
- Output decode is combinational from state; registers update on `clk` only.
- Single-byte frame, accept at cycle 0:
  - CLR at cycle 1.
  - SHIFT at cycles 2–9.
  - FLUSH at cycles 10–41.
  - `out_valid` first high in cycle 42.
- N back-to-back bytes: `out_valid` at cycle 2+8N+32.
- `rst` dominates `abort`; `abort` dominates handshakes.

## Configuration
- `CRC32_AUGMENT_EN` defined:
  - FLUSH state is present.
  - 32 zero bits are appended after the last byte (augmented-message engine).
- Not defined:
  - FLUSH is compiled out; SHIFT of the last byte goes directly to DONE.
  - Single-byte frame `out_valid` occurs at cycle 10 (direct-form engine).

## Test plan
- Reset, then single byte 0x00 with `in_last=1`, `out_ready=1` → `out_valid` only in cycle 42 (10 without augment), `out_crc=0x00000000`, `out_len=1`, then IDLE with `in_ready=1`.
- Frame "123456789" sent back-to-back (0x31..0x39) → `in_ready` high only at `bit_cnt==7`; `crc_bit` sequence equals the bytes LSB-first plus 32 zeros; `out_crc` matches the standalone engine fed the same bits; `out_len=9`; `out_valid` at cycle 106.
- Same frame with `in_valid` dropped 5 cycles after byte 3 → WAIT for 5 cycles with `crc_en=0`; `out_crc` identical to the back-to-back run; `out_valid` 5 cycles later.
- `out_ready=0` for 10 cycles in DONE → `out_valid` and `out_crc` held constant; `crc_en=0`; `in_ready=0`; IDLE only after the `out_ready` cycle.
- `abort` during SHIFT of byte 2, and separately `rst` during FLUSH → IDLE next cycle, no `out_valid`; a following 0x00 frame yields 0x00000000 (CLR re-clears).
- 70000-byte frame with `LEN_W=16` → `out_len=0xFFFF` (saturated).

Source files
------------

// File: rtl/crc32_stream_ctrl_if.sv
// rtl/crc32_stream_ctrl_if.sv - byte stream, CRC engine and result signals for crc32_stream_ctrl
interface crc32_stream_ctrl_if #(
    parameter int LEN_W = 16
) ();
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             abort;
    logic             crc_clr;
    logic             crc_en;
    logic             crc_bit;
    logic [31:0]      crc_val;
    logic             out_valid;
    logic [31:0]      out_crc;
    logic [LEN_W-1:0] out_len;
    logic             out_ready;

    modport master (
        output in_valid, in_data, in_last, abort, crc_val, out_ready,
        input  in_ready, crc_clr, crc_en, crc_bit, out_valid, out_crc, out_len
    );

    modport slave (
        input  in_valid, in_data, in_last, abort, crc_val, out_ready,
        output in_ready, crc_clr, crc_en, crc_bit, out_valid, out_crc, out_len
    );
endinterface

// File: rtl/crc32_stream_ctrl.sv
// rtl/crc32_stream_ctrl.sv - byte-to-bit sequencer for a serial CRC-32 engine
// CRC32_AUGMENT_EN adds the FLUSH state that appends 32 zero bits after the last byte.
module crc32_stream_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    crc32_stream_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_WAIT,
`ifdef CRC32_AUGMENT_EN
        S_FLUSH,
`endif
        S_DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_sh;
    logic [2:0]       r_bit_cnt;
    logic             r_last;
    logic [LEN_W-1:0] r_len;
`ifdef CRC32_AUGMENT_EN
    logic [4:0]       r_flush_cnt;
`endif

    logic             w_busy;
    logic             w_abort;
    logic             w_shift_end;
    logic             w_in_ready;
    logic             w_accept;
    logic [LEN_W-1:0] w_len_inc;

    assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_abort     = bus.abort && w_busy;
    assign w_shift_end = (r_state == S_SHIFT) && (r_bit_cnt == 3'd7);
    // A new byte is only taken on the last bit of the current one, so throughput stays 8 cycles/byte.
    assign w_in_ready  = !w_abort && ((r_state == S_IDLE) || (r_state == S_WAIT) ||
                                      (w_shift_end && !r_last));
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_len_inc   = (&r_len) ? r_len : r_len + LEN_W'(1);

    assign bus.in_ready  = w_in_ready;
    assign bus.crc_clr   = (r_state == S_CLR);
`ifdef CRC32_AUGMENT_EN
    assign bus.crc_en    = (r_state == S_SHIFT) || (r_state == S_FLUSH);
`else
    assign bus.crc_en    = (r_state == S_SHIFT);
`endif
    assign bus.crc_bit   = (r_state == S_SHIFT) && r_sh[0];
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_crc   = (r_state == S_DONE) ? bus.crc_val : 32'd0;
    assign bus.out_len   = (r_state == S_DONE) ? r_len : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sh        <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_last      <= 1'b0;
            r_len       <= '0;
`ifdef CRC32_AUGMENT_EN
            r_flush_cnt <= 5'd0;
`endif
        end else if (w_abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sh    <= bus.in_data;
                        r_last  <= bus.in_last;
                        r_len   <= LEN_W'(1);
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_bit_cnt <= 3'd0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_sh      <= r_sh >> 1;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (w_accept) begin
                            r_sh   <= bus.in_data;
                            r_last <= bus.in_last;
                            r_len  <= w_len_inc;
                        end else if (r_last) begin
`ifdef CRC32_AUGMENT_EN
                            r_flush_cnt <= 5'd0;
                            r_state     <= S_FLUSH;
`else
                            r_state     <= S_DONE;
`endif
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_accept) begin
                        r_sh      <= bus.in_data;
                        r_last    <= bus.in_last;
                        r_len     <= w_len_inc;
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_SHIFT;
                    end
                end
`ifdef CRC32_AUGMENT_EN
                S_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + 5'd1;
                    if (r_flush_cnt == 5'd31) begin
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc32_stream_ctrl.sv
// tb/tb_crc32_stream_ctrl.sv - directed bench for crc32_stream_ctrl with a frame-level reference model
module tb_crc32_stream_ctrl;
    localparam int LEN_W = 4;
`ifdef CRC32_AUGMENT_EN
    localparam int FLUSH_N = 32;
`else
    localparam int FLUSH_N = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc32_stream_ctrl_if #(.LEN_W(LEN_W)) bus ();
    crc32_stream_ctrl #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reflected CRC-32, one message bit at a time
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
    endfunction

    function automatic logic [31:0] crc_bytes(input byte q[$], input logic [31:0] init, input int zeros);
        logic [31:0] c;
        c = init;
        foreach (q[i]) for (int b = 0; b < 8; b++) c = crc_step(c, q[i][b]);
        for (int z = 0; z < zeros; z++) c = crc_step(c, 1'b0);
        return c;
    endfunction

    logic [31:0] eng = 32'd0;
    always @(posedge clk) begin
        if (bus.crc_clr)     eng <= 32'd0;
        else if (bus.crc_en) eng <= crc_step(eng, bus.crc_bit);
    end
    assign bus.crc_val = eng;

    // Reference state for the current frame
    bit          active    = 0;
    bit          seen      = 0;
    int          t0        = 0;
    int          wait_cnt  = 0;
    int          exp_len   = 0;
    int          exp_gap   = 0;
    byte         acc[$];
    bit          got[$];
    logic [31:0] held_crc  = 0;
    int          last_rel  = -1;
    logic [31:0] last_crc  = 0;
    int          last_len  = -1;

    always @(negedge clk) begin
        if (rst) begin
            active = 0;
        end else begin
            if (!bus.out_valid) begin
                chk("out_crc_zero", bus.out_crc, 32'd0);
                chk("out_len_zero", 32'(bus.out_len), 32'd0);
            end
            if (!bus.crc_en) chk("crc_bit_idle", 32'(bus.crc_bit), 32'd0);
            chk("clr_en_excl", 32'(bus.crc_clr & bus.crc_en), 32'd0);
            if (!active) begin
                chk("idle_no_valid", 32'(bus.out_valid), 32'd0);
                chk("idle_ready", 32'(bus.in_ready), 32'd1);
                if (bus.in_valid && bus.in_ready) begin
                    active = 1; seen = 0; t0 = cyc; wait_cnt = 0;
                    acc.delete(); got.delete();
                    acc.push_back(bus.in_data);
                end
            end else if (bus.abort && !bus.out_valid) begin
                chk("abort_ready_low", 32'(bus.in_ready), 32'd0);
                active = 0;
            end else begin
                if (bus.crc_en) begin
                    got.push_back(bus.crc_bit);
                    if (bus.in_ready) chk("ready_on_bit7", 32'(got.size() % 8), 32'd0);
                end
                if (!bus.out_valid && !bus.crc_en && !bus.crc_clr) begin
                    wait_cnt++;
                    chk("wait_ready", 32'(bus.in_ready), 32'd1);
                end
                if (bus.in_valid && bus.in_ready) acc.push_back(bus.in_data);
                if (bus.out_valid) begin
                    chk("done_crc_en", 32'(bus.crc_en), 32'd0);
                    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
                    if (!seen) begin
                        int bad;
                        bad = 0;
                        if (got.size() != acc.size() * 8 + FLUSH_N) bad = 1;
                        else begin
                            foreach (acc[i]) for (int b = 0; b < 8; b++)
                                if (got[i*8+b] != acc[i][b]) bad++;
                            for (int z = 0; z < FLUSH_N; z++) if (got[acc.size()*8+z] != 1'b0) bad++;
                        end
                        chk("bitstream", 32'(bad), 32'd0);
                        chk("valid_cycle", 32'(cyc - t0), 32'(2 + 8*exp_len + FLUSH_N + exp_gap));
                        chk("wait_cycles", 32'(wait_cnt), 32'(exp_gap));
                        chk("out_crc", bus.out_crc, crc_bytes(acc, 32'd0, FLUSH_N));
                        chk("out_len", 32'(bus.out_len),
                            32'((acc.size() > 15) ? 15 : acc.size()));
                        held_crc = bus.out_crc;
                        last_rel = cyc - t0;
                        last_crc = bus.out_crc;
                        last_len = int'(bus.out_len);
                        seen = 1;
                    end else begin
                        chk("held_crc", bus.out_crc, held_crc);
                    end
                    if (bus.out_ready) active = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.in_ready) return;
        end
        chk("timeout_in_ready", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input byte q[$], input int gap_idx, input int gap);
        exp_len = q.size();
        exp_gap = (gap_idx >= 0) ? gap : 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i == gap_idx) begin
                wait_ready();
                repeat (gap) @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = q[i];
            bus.in_last  = (i == q.size() - 1);
            wait_ready();
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic wait_valid();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.out_valid) return;
        end
        chk("timeout_out_valid", 32'd0, 32'd1);
    endtask

    task automatic finish_frame();
        wait_valid();
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        byte q[$];
        byte z[$];
        logic [31:0] crc_b2b;

        bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0;
        bus.abort = 0; bus.out_ready = 1;

        // Model pins: standard CRC-32 check value and single-bit impulse
        for (int i = 0; i < 9; i++) q.push_back(byte'(8'h31 + i));
        chk("pin_check_value", crc_bytes(q, 32'hFFFFFFFF, 0) ^ 32'hFFFFFFFF, 32'hCBF43926);
        z.push_back(8'h80);
        chk("pin_impulse", crc_bytes(z, 32'd0, 0), 32'hEDB88320);
        z.delete(); z.push_back(8'h00);

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_crc_en", 32'(bus.crc_en), 32'd0);
        chk("rst_crc_clr", 32'(bus.crc_clr), 32'd0);
        @(posedge clk); #1;

        send_frame(z, -1, 0);
        finish_frame();
        chk("single_rel", 32'(last_rel), (FLUSH_N == 32) ? 32'd42 : 32'd10);
        chk("single_crc", last_crc, 32'd0);
        chk("single_len", 32'(last_len), 32'd1);

        send_frame(q, -1, 0);
        finish_frame();
        chk("b2b_rel", 32'(last_rel), (FLUSH_N == 32) ? 32'd106 : 32'd74);
        chk("b2b_len", 32'(last_len), 32'd9);
        crc_b2b = last_crc;

        send_frame(q, 3, 5);
        finish_frame();
        chk("gap_rel", 32'(last_rel), (FLUSH_N == 32) ? 32'd111 : 32'd79);
        chk("gap_crc_same", last_crc, crc_b2b);

        // Result held while the consumer stalls for 10 cycles
        bus.out_ready = 0;
        send_frame(q, -1, 0);
        wait_valid();
        repeat (10) @(posedge clk);
        #1 bus.out_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_idle_after", 32'(bus.in_ready), 32'd1);
        chk("stall_crc", last_crc, crc_b2b);
        @(posedge clk); #1;

        // Abort during byte 2 shift, with a byte offered in the abort cycle
        bus.in_valid = 1; bus.in_data = 8'hA5; bus.in_last = 0;
        wait_ready(); @(posedge clk); #1;
        bus.in_data = 8'h5A;
        wait_ready(); @(posedge clk); #1;
        bus.in_valid = 0;
        repeat (3) @(posedge clk);
        #1 bus.abort = 1; bus.in_valid = 1; bus.in_data = 8'hFF;
        @(posedge clk); #1 bus.abort = 0; bus.in_valid = 0;
        repeat (60) @(posedge clk);
        #1;
        send_frame(z, -1, 0);
        finish_frame();
        chk("abort_next_crc", last_crc, 32'd0);

        // Reset in FLUSH (or mid-SHIFT without augmentation)
        z.delete(); z.push_back(8'h55);
        send_frame(z, -1, 0);
        repeat ((FLUSH_N == 32) ? 15 : 3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        repeat (60) @(posedge clk);
        #1;
        z.delete(); z.push_back(8'h00);
        send_frame(z, -1, 0);
        finish_frame();
        chk("rst_next_crc", last_crc, 32'd0);

        // Length counter saturation with LEN_W=4
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(byte'(8'h10 + i));
        send_frame(q, -1, 0);
        finish_frame();
        chk("sat_len", 32'(last_len), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
